// File: rtl/pipe_pkg.sv
// Shared definitions for the pipelined CPU front end: PC-source encodings,
// fetch-state enum and the bubble instruction word.
package pipe_pkg;

    localparam logic [1:0] PCS_SEQ = 2'b00;
    localparam logic [1:0] PCS_BR  = 2'b01;
    localparam logic [1:0] PCS_JR  = 2'b10;
    localparam logic [1:0] PCS_J   = 2'b11;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

    // sll $0,$0,0 -- what decode sees when fetch has nothing to deliver
    localparam logic [31:0] INST_NOP = 32'h0000_0000;

endpackage

// File: rtl/pipeif_pcsel.sv
// Redirect target select: picks bpc/ra/jpc by pcsource and forces word alignment.
module pipeif_pcsel
    import pipe_pkg::*;
(
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] jpc,
    input  logic [31:0] ra,
    output logic [31:0] target
);

    logic [31:0] sel;

    always_comb begin
        sel = '0;
        unique case (pcsource)
            PCS_BR:  sel = bpc;
            PCS_JR:  sel = ra;
            PCS_J:   sel = jpc;
            default: sel = '0;
        endcase
        target = sel & 32'hFFFF_FFFC;
    end

endmodule

// File: rtl/pipeif_fetch.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding req/gnt/rvalid
// fetch, and loads the IF/ID register with delay-slot redirect handling.
module pipeif_fetch
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] jpc,
    input  logic [31:0] ra,
    input  logic        nostall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] dpc4,
    output logic [31:0] inst,
    output logic [31:0] pc
);

    fetch_state_e state, state_next;

    logic [31:0] inst_buf;
    logic [31:0] redir_tgt;
    logic        redir_pend;
    logic [31:0] sel_tgt;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic [31:0] deliver_inst;
    logic        capture;
    logic        deliver;
    logic        hold_load;

    pipeif_pcsel u_pcsel (
        .pcsource (pcsource),
        .bpc      (bpc),
        .jpc      (jpc),
        .ra       (ra),
        .target   (sel_tgt)
    );

    // A redirect is only taken while decode is accepting; a stalled branch re-presents it.
    assign capture  = nostall && (pcsource != PCS_SEQ);
    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        if (capture)         next_pc = sel_tgt;
        else if (redir_pend) next_pc = redir_tgt;
        else                 next_pc = pc_plus4;
    end

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        state_next   = state;
        deliver      = 1'b0;
        hold_load    = 1'b0;
        deliver_inst = inst_buf;
        unique case (state)
            ST_REQ: begin
                if (imem_gnt) state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    if (nostall) begin
                        deliver      = 1'b1;
                        deliver_inst = imem_rdata;
                        state_next   = ST_REQ;
                    end else begin
                        hold_load  = 1'b1;
                        state_next = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (nostall) begin
                    deliver    = 1'b1;
                    state_next = ST_REQ;
                end
            end
            default: state_next = ST_REQ;
        endcase
    end

    // Request depends on registered state only, so decode timing never reaches memory.
    assign imem_req  = (state == ST_REQ) && !clr;
    assign imem_addr = pc & 32'hFFFF_FFFC;

    always_ff @(posedge clk) begin
        if (clr) begin
            state      <= ST_REQ;
            pc         <= RESET_PC;
            inst       <= INST_NOP;
            dpc4       <= '0;
            inst_buf   <= '0;
            redir_tgt  <= '0;
            redir_pend <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all regs update together.
            state <= state_next;
            if (hold_load) inst_buf <= imem_rdata;
            if (deliver) begin
                inst       <= deliver_inst;
                dpc4       <= pc_plus4;
                pc         <= next_pc;
                redir_pend <= 1'b0;
            end else begin
                if (nostall) inst <= INST_NOP;
                if (capture) begin
                    redir_tgt  <= sel_tgt;
                    redir_pend <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipeif_fetch.sv
// Directed bench for pipeif_fetch with a latency-configurable instruction memory
// that returns a tagged copy of the fetch address.
module tb_pipeif_fetch;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [1:0]  pcsource = PCS_SEQ;
    logic [31:0] bpc = '0;
    logic [31:0] jpc = '0;
    logic [31:0] ra = '0;
    logic        nostall = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'hDEAD_BEEF;
    logic [31:0] dpc4;
    logic [31:0] inst;
    logic [31:0] pc;

    int n_checks = 0;
    int n_fail   = 0;

    // memory model knobs
    int gnt_wait = 0;
    int lat      = 1;

    pipeif_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .clr         (clr),
        .pcsource    (pcsource),
        .bpc         (bpc),
        .jpc         (jpc),
        .ra          (ra),
        .nostall     (nostall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .dpc4        (dpc4),
        .inst        (inst),
        .pc          (pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {8'hA5, a[23:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Memory: grants after gnt_wait REQ cycles, returns data lat cycles after grant.
    initial begin : mem_model
        logic        pending;
        int          cnt;
        int          req_cnt;
        logic [31:0] paddr;
        logic [31:0] gaddr;
        pending = 1'b0;
        cnt = 0;
        req_cnt = 0;
        paddr = '0;
        gaddr = '0;
        forever begin
            @(posedge clk);
            #2;
            if (clr) begin
                pending     = 1'b0;
                req_cnt     = 0;
                imem_gnt    = 1'b0;
                imem_rvalid = 1'b0;
                imem_rdata  = 32'hDEAD_BEEF;
            end else begin
                if (imem_rvalid) pending = 1'b0;
                if (imem_gnt) begin
                    pending = 1'b1;
                    paddr   = gaddr;
                    cnt     = lat - 1;
                end else if (pending && cnt > 0) begin
                    cnt--;
                end
                imem_rvalid = pending && (cnt == 0);
                imem_rdata  = imem_rvalid ? word_at(paddr) : 32'hDEAD_BEEF;
                imem_gnt    = 1'b0;
                if (imem_req && !pending) begin
                    if (req_cnt < gnt_wait) begin
                        req_cnt++;
                    end else begin
                        imem_gnt = 1'b1;
                        gaddr    = imem_addr;
                        req_cnt  = 0;
                    end
                end
            end
        end
    end

    initial begin : stim
        // reset
        tick();
        tick();
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_inst", inst, 32'h0);
        check("rst_dpc4", dpc4, 32'h0);
        check("rst_pc", pc, 32'h0);
        clr = 1'b0;
        #1;
        check("first_req", {31'd0, imem_req}, 32'd1);
        check("first_addr", imem_addr, 32'h0);

        // zero-wait memory: bubble, word, bubble, word ...
        for (int k = 0; k < 3; k++) begin
            tick();
            check("zw_bubble", inst, 32'h0);
            check("zw_req_wait", {31'd0, imem_req}, 32'd0);
            tick();
            check("zw_inst", inst, word_at(32'(4 * k)));
            check("zw_dpc4", dpc4, 32'(4 * k + 4));
            check("zw_addr", imem_addr, 32'(4 * k + 4));
        end

        // grant withheld for 3 cycles at pc=0xC
        gnt_wait = 3;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("gw_req", {31'd0, imem_req}, 32'd1);
            check("gw_addr", imem_addr, 32'hC);
            check("gw_inst", inst, 32'h0);
            check("gw_pc", pc, 32'hC);
        end
        gnt_wait = 0;
        tick();
        check("gw_wait", {31'd0, imem_req}, 32'd0);
        tick();
        check("gw_deliver", inst, word_at(32'hC));
        check("gw_dpc4", dpc4, 32'h10);
        check("gw_next", imem_addr, 32'h10);

        // stall when the word at 0x10 arrives: HOLD, then release two cycles later
        nostall = 1'b0;
        tick();
        check("st_hold0", inst, word_at(32'hC));
        tick();
        check("st_hold1", inst, word_at(32'hC));
        check("st_hold1_dpc4", dpc4, 32'h10);
        check("st_hold1_req", {31'd0, imem_req}, 32'd0);
        tick();
        check("st_hold2", inst, word_at(32'hC));
        check("st_hold2_pc", pc, 32'h10);
        nostall = 1'b1;
        tick();
        check("st_release", inst, word_at(32'h10));
        check("st_dpc4", dpc4, 32'h14);
        check("st_addr", imem_addr, 32'h14);
        check("st_req", {31'd0, imem_req}, 32'd1);

        // run ahead to the request for 0x24 (bounded)
        for (int i = 0; i < 40 && !(imem_req && imem_addr == 32'h24); i++) tick();
        check("reach_24", imem_addr, 32'h24);
        check("reach_24_dpc4", dpc4, 32'h24);

        // branch in decode while delay slot 0x24 waits 4 cycles
        lat = 4;
        tick();
        check("br_wait", {31'd0, imem_req}, 32'd0);
        pcsource = PCS_BR;
        bpc = 32'h0000_0103;
        tick();
        pcsource = PCS_SEQ;
        bpc = '0;
        lat = 1;
        check("br_pc_hold", pc, 32'h24);
        tick();
        check("br_still_wait", {31'd0, imem_req}, 32'd0);
        tick();
        check("br_pc_hold2", pc, 32'h24);
        tick();
        check("br_slot_inst", inst, word_at(32'h24));
        check("br_slot_dpc4", dpc4, 32'h28);
        check("br_target", imem_addr, 32'h100);
        tick();
        tick();
        check("br_tgt_inst", inst, word_at(32'h100));
        check("br_tgt_dpc4", dpc4, 32'h104);

        // jump presented while stalled is ignored
        nostall = 1'b0;
        pcsource = PCS_J;
        jpc = 32'h300;
        tick();
        check("j_ign_hold", inst, word_at(32'h100));
        nostall = 1'b1;
        pcsource = PCS_SEQ;
        tick();
        check("j_ign_inst", inst, word_at(32'h104));
        check("j_ign_addr", imem_addr, 32'h108);

        // jump held through a stall, captured on the delay-slot delivery cycle
        pcsource = PCS_J;
        jpc = 32'h200;
        nostall = 1'b0;
        tick();
        check("j_stall_hold", inst, word_at(32'h104));
        nostall = 1'b1;
        tick();
        pcsource = PCS_SEQ;
        check("j_slot_inst", inst, word_at(32'h108));
        check("j_slot_dpc4", dpc4, 32'h10C);
        check("j_target", imem_addr, 32'h200);
        tick();
        check("j_bubble", inst, 32'h0);
        tick();
        check("j_tgt_inst", inst, word_at(32'h200));
        check("j_tgt_dpc4", dpc4, 32'h204);

        // reset while in HOLD with a pending redirect
        pcsource = PCS_BR;
        bpc = 32'h400;
        tick();
        pcsource = PCS_SEQ;
        nostall = 1'b0;
        tick();
        check("cl_hold_req", {31'd0, imem_req}, 32'd0);
        check("cl_hold_pc", pc, 32'h204);
        clr = 1'b1;
        tick();
        check("cl_inst", inst, 32'h0);
        check("cl_dpc4", dpc4, 32'h0);
        check("cl_pc", pc, 32'h0);
        check("cl_req_low", {31'd0, imem_req}, 32'd0);
        clr = 1'b0;
        nostall = 1'b1;
        #1;
        check("cl_req", {31'd0, imem_req}, 32'd1);
        check("cl_addr", imem_addr, 32'h0);
        tick();
        check("cl_bubble", inst, 32'h0);
        tick();
        check("cl_inst0", inst, word_at(32'h0));
        check("cl_dpc4_4", dpc4, 32'h4);
        check("cl_no_redirect", imem_addr, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
